// File: rtl/mixer_pkg.sv
// -----------------------------------------------------------------------------
// mixer_pkg
// Shared constants and types for the 4-channel mixer gain controller.
//   GW    : gain word width, unsigned 4.4 fixed point
//   NCH   : number of mixer channels
//   CW    : channel index width
//   AW    : limiter attenuation level width
//   UNITY : 1.0 in 4.4 format
// -----------------------------------------------------------------------------
package mixer_pkg;

    localparam int GW  = 8;
    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int AW  = 2;

    localparam logic [GW-1:0] UNITY = 8'h10;

    typedef logic [GW-1:0] gain_t;
    typedef logic [AW-1:0] att_t;

    // Direction a channel's gain moves on the current clk.
    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN
    } step_e;

    // Target the ramp actually heads for: muted channels go to silence,
    // otherwise each limiter level halves the programmed gain.
    function automatic gain_t eff_gain(input gain_t tgt, input att_t att, input logic mute);
        return mute ? '0 : (tgt >> att);
    endfunction

endpackage

// File: rtl/gain_ramp.sv
// -----------------------------------------------------------------------------
// gain_ramp
// One mixer channel: holds the CPU-programmed target gain and the current
// gain, and walks the current gain one LSB at a time toward the effective
// target (target after mute and limiter attenuation).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   we_i, wdata_i : target write strobe and new 4.4 target
//   att_i, mute_i : limiter level and mute, applied to the target
//   up_tick_i     : permission to step upward this clk
//   dn_tick_i     : permission to step downward this clk
//   gain_o        : current gain
//   busy_o        : current gain differs from effective target
// -----------------------------------------------------------------------------
module gain_ramp
    import mixer_pkg::*;
#(
    parameter gain_t RST_TGT = UNITY
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [GW-1:0] wdata_i,
    input  logic [AW-1:0] att_i,
    input  logic          mute_i,
    input  logic          up_tick_i,
    input  logic          dn_tick_i,
    output logic [GW-1:0] gain_o,
    output logic          busy_o
);

    gain_t target_q, target_d;
    gain_t gain_q, gain_d;
    gain_t eff;
    step_e step;

    always_comb begin
        // The comparison always uses the registered target, so a write that
        // lands on a tick clk only takes effect from the following clk.
        eff  = eff_gain(target_q, att_i, mute_i);
        step = STEP_HOLD;
        if (gain_q < eff && up_tick_i) begin
            step = STEP_UP;
        end else if (gain_q > eff && dn_tick_i) begin
            step = STEP_DOWN;
        end
        // Stepping only toward eff means no overshoot and no wrap at the ends.
        case (step)
            STEP_UP:   gain_d = gain_q + 1'b1;
            STEP_DOWN: gain_d = gain_q - 1'b1;
            default:   gain_d = gain_q;
        endcase
        target_d = we_i ? wdata_i : target_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= RST_TGT;
            gain_q   <= '0;
        end else begin
            target_q <= target_d;
            gain_q   <= gain_d;
        end
    end

    assign gain_o = gain_q;
    assign busy_o = (gain_q != eff);

endmodule

// File: rtl/mixer_gain_ctrl.sv
// -----------------------------------------------------------------------------
// mixer_gain_ctrl
// Run-time gain controller feeding the 4-channel unsigned mixer. Produces
// four 4.4 gains that ramp smoothly toward CPU-written targets, with mute and
// a peak-driven limiter that attenuates all channels by right shifts.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cen             : mixer clock enable; all timing counters advance on it
//   wr, waddr, wdata: target write (not gated by cen)
//   mute            : force all effective targets to 0
//   peak            : mixer overflow flag, sampled when cen=1
//   gain0..gain3    : current per-channel gains
//   att             : current limiter attenuation level
//   ramping         : registered "some gain is still moving"
// -----------------------------------------------------------------------------
module mixer_gain_ctrl
    import mixer_pkg::*;
#(
    parameter int          UP_DIV    = 256,
    parameter int          DN_DIV    = 16,
    parameter int          PEAK_HOLD = 1024,
    parameter int          MAX_ATT   = 3,
    parameter logic [7:0]  RST_TGT   = 8'h10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          wr,
    input  logic [CW-1:0] waddr,
    input  logic [GW-1:0] wdata,
    input  logic          mute,
    input  logic          peak,
    output logic [GW-1:0] gain0,
    output logic [GW-1:0] gain1,
    output logic [GW-1:0] gain2,
    output logic [GW-1:0] gain3,
    output logic [AW-1:0] att,
    output logic          ramping
);

    // Widths sized with +1 so a divider of 1 still gets a 1-bit counter.
    localparam int UW = $clog2(UP_DIV + 1);
    localparam int DW = $clog2(DN_DIV + 1);
    localparam int HW = $clog2(PEAK_HOLD + 1);

    localparam logic [UW-1:0] UP_LAST   = UW'(UP_DIV - 1);
    localparam logic [DW-1:0] DN_LAST   = DW'(DN_DIV - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(PEAK_HOLD - 1);
    localparam logic [AW-1:0] ATT_MAX   = AW'(MAX_ATT);

    logic [UW-1:0] up_cnt_q, up_cnt_d;
    logic [DW-1:0] dn_cnt_q, dn_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] att_q, att_d;
    logic          ramping_q;
    logic          up_tick, dn_tick;

    gain_t            gain_w [NCH];
    logic [NCH-1:0]   busy_w;

    // Step-rate dividers.
    always_comb begin
        up_tick  = cen && (up_cnt_q == UP_LAST);
        dn_tick  = cen && (dn_cnt_q == DN_LAST);
        up_cnt_d = up_cnt_q;
        dn_cnt_d = dn_cnt_q;
        if (cen) begin
            up_cnt_d = up_tick ? '0 : up_cnt_q + 1'b1;
            dn_cnt_d = dn_tick ? '0 : dn_cnt_q + 1'b1;
        end
    end

    // Limiter: attack one level per peaked cen, release one level after
    // PEAK_HOLD peak-free cen ticks.
    always_comb begin
        att_d  = att_q;
        hold_d = hold_q;
        if (cen) begin
            if (peak) begin
                att_d  = (att_q == ATT_MAX) ? att_q : att_q + 1'b1;
                hold_d = HOLD_INIT;
            end else if (hold_q == '0) begin
                att_d  = (att_q == '0) ? att_q : att_q - 1'b1;
                hold_d = HOLD_INIT;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_cnt_q  <= '0;
            dn_cnt_q  <= '0;
            hold_q    <= HOLD_INIT;
            att_q     <= '0;
            ramping_q <= 1'b0;
        end else begin
            up_cnt_q  <= up_cnt_d;
            dn_cnt_q  <= dn_cnt_d;
            hold_q    <= hold_d;
            att_q     <= att_d;
            ramping_q <= |busy_w;
        end
    end

    // One ramp per channel; write decode selects which target takes wdata.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            gain_ramp #(
                .RST_TGT (RST_TGT)
            ) u_ramp (
                .clk       (clk),
                .rst       (rst),
                .we_i      (wr && (waddr == CW'(gi))),
                .wdata_i   (wdata),
                .att_i     (att_q),
                .mute_i    (mute),
                .up_tick_i (up_tick),
                .dn_tick_i (dn_tick),
                .gain_o    (gain_w[gi]),
                .busy_o    (busy_w[gi])
            );
        end
    endgenerate

    assign gain0   = gain_w[0];
    assign gain1   = gain_w[1];
    assign gain2   = gain_w[2];
    assign gain3   = gain_w[3];
    assign att     = att_q;
    assign ramping = ramping_q;

endmodule

// File: tb/tb_mixer_gain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mixer_gain_ctrl
// Directed vector table plus randomized traffic, with every cycle compared
// against a behavioural model of the gain controller.
// -----------------------------------------------------------------------------
module tb_mixer_gain_ctrl;

    localparam int UP_DIV    = 4;
    localparam int DN_DIV    = 1;
    localparam int PEAK_HOLD = 8;
    localparam int MAX_ATT   = 3;
    localparam int NVEC      = 32;

    logic       clk = 1'b0;
    logic       rst, cen, wr, mute, peak;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [7:0] gain0, gain1, gain2, gain3;
    logic [1:0] att;
    logic       ramping;

    always #5 clk = ~clk;

    mixer_gain_ctrl #(
        .UP_DIV    (UP_DIV),
        .DN_DIV    (DN_DIV),
        .PEAK_HOLD (PEAK_HOLD),
        .MAX_ATT   (MAX_ATT),
        .RST_TGT   (8'h10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .wr      (wr),
        .waddr   (waddr),
        .wdata   (wdata),
        .mute    (mute),
        .peak    (peak),
        .gain0   (gain0),
        .gain1   (gain1),
        .gain2   (gain2),
        .gain3   (gain3),
        .att     (att),
        .ramping (ramping)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model state.
    int m_tgt [4];
    int m_gain[4];
    int m_att, m_hold, m_ramp, m_ticks;

    function automatic void model_clk(input logic r, input logic c, input logic w,
                                      input logic [1:0] a, input logic [7:0] d,
                                      input logic m, input logic p);
        bit up, dn;
        int e;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_tgt[i]  = 16;
                m_gain[i] = 0;
            end
            m_att = 0; m_hold = PEAK_HOLD - 1; m_ramp = 0; m_ticks = 0;
            return;
        end
        up = c && ((m_ticks % UP_DIV) == UP_DIV - 1);
        dn = c && ((m_ticks % DN_DIV) == DN_DIV - 1);
        m_ramp = 0;
        for (int i = 0; i < 4; i++) begin
            e = m ? 0 : m_tgt[i] / (1 << m_att);
            if (m_gain[i] != e) m_ramp = 1;
            if (m_gain[i] < e && up) m_gain[i]++;
            else if (m_gain[i] > e && dn) m_gain[i]--;
        end
        if (c) begin
            if (p) begin
                m_att  = (m_att < MAX_ATT) ? m_att + 1 : MAX_ATT;
                m_hold = PEAK_HOLD - 1;
            end else if (m_hold == 0) begin
                m_att  = (m_att > 0) ? m_att - 1 : 0;
                m_hold = PEAK_HOLD - 1;
            end else begin
                m_hold--;
            end
            m_ticks++;
        end
        if (w) m_tgt[a] = d;
    endfunction

    task automatic check_model();
        logic [31:0] eg, ag;
        eg = {8'(m_gain[3]), 8'(m_gain[2]), 8'(m_gain[1]), 8'(m_gain[0])};
        ag = {gain3, gain2, gain1, gain0};
        n_checks++;
        if (ag !== eg || att !== 2'(m_att) || ramping !== 1'(m_ramp)) begin
            n_fail++;
            $display("FAIL model cyc=%0d got gains=%h att=%0d ramping=%0d, want gains=%h att=%0d ramping=%0d",
                     cyc, ag, att, ramping, eg, m_att, m_ramp);
        end
    endtask

    // Drive one clk worth of inputs, advance the model, compare after the edge.
    task automatic apply(input logic r, input logic c, input logic w, input logic [1:0] a,
                         input logic [7:0] d, input logic m, input logic p);
        rst = r; cen = c; wr = w; waddr = a; wdata = d; mute = m; peak = p;
        @(posedge clk);
        model_clk(r, c, w, a, d, m, p);
        cyc++;
        #1;
        check_model();
    endtask

    typedef struct {
        logic        rst, cen, wr;
        logic [1:0]  waddr;
        logic [7:0]  wdata;
        logic        mute, peak;
        int          n;
        logic        chk_g;
        logic [31:0] e_g;
        logic [1:0]  e_att;
        logic        chk_r;
        logic        e_r;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic r, input logic c, input logic w, input logic [1:0] a,
                                input logic [7:0] d, input logic m, input logic p, input int n,
                                input logic cg, input logic [31:0] eg, input logic [1:0] ea,
                                input logic cr, input logic er);
        vec_t v;
        v.rst = r; v.cen = c; v.wr = w; v.waddr = a; v.wdata = d; v.mute = m; v.peak = p;
        v.n = n; v.chk_g = cg; v.e_g = eg; v.e_att = ea; v.chk_r = cr; v.e_r = er;
        return v;
    endfunction

    logic [31:0] act_g;
    logic        rmute;

    initial begin
        //             rst cen wr  a  wdata mute peak   n  chk_g  gains          att chk_r ramp
        vecs[0]  = mk(1, 1, 0, 0, 8'h00, 0, 0,   2, 1, 32'h00000000, 0, 1, 0); // reset state
        vecs[1]  = mk(0, 1, 0, 0, 8'h00, 0, 0,  64, 1, 32'h10101010, 0, 1, 1); // soft start done
        vecs[2]  = mk(0, 1, 0, 0, 8'h00, 0, 0,   1, 1, 32'h10101010, 0, 1, 0); // ramping falls
        vecs[3]  = mk(0, 1, 1, 2, 8'h04, 0, 0,   1, 1, 32'h10101010, 0, 1, 0); // write ch2
        vecs[4]  = mk(0, 1, 0, 0, 8'h00, 0, 0,  12, 1, 32'h10041010, 0, 1, 1); // ch2 down
        vecs[5]  = mk(0, 1, 0, 0, 8'h00, 0, 0,   1, 1, 32'h10041010, 0, 1, 0);
        vecs[6]  = mk(0, 1, 1, 2, 8'h10, 0, 0,   1, 1, 32'h10041010, 0, 1, 0);
        vecs[7]  = mk(0, 1, 0, 0, 8'h00, 0, 0,  60, 1, 32'h10101010, 0, 1, 0);
        vecs[8]  = mk(0, 1, 0, 0, 8'h00, 1, 0,  16, 1, 32'h00000000, 0, 1, 1); // mute
        vecs[9]  = mk(0, 1, 0, 0, 8'h00, 1, 0,   1, 1, 32'h00000000, 0, 1, 0);
        vecs[10] = mk(0, 1, 0, 0, 8'h00, 0, 0,  64, 1, 32'h10101010, 0, 0, 0); // unmute
        vecs[11] = mk(0, 1, 0, 0, 8'h00, 0, 0,   4, 1, 32'h10101010, 0, 1, 0);
        vecs[12] = mk(0, 1, 0, 0, 8'h00, 0, 1,   2, 0, 32'h00000000, 2, 0, 0); // two peaks
        vecs[13] = mk(0, 1, 0, 0, 8'h00, 0, 0,   7, 0, 32'h00000000, 2, 0, 0); // hold
        vecs[14] = mk(0, 1, 0, 0, 8'h00, 0, 0,   1, 0, 32'h00000000, 1, 0, 0); // release 1
        vecs[15] = mk(0, 1, 0, 0, 8'h00, 0, 0,   7, 0, 32'h00000000, 1, 0, 0);
        vecs[16] = mk(0, 1, 0, 0, 8'h00, 0, 0,   1, 0, 32'h00000000, 0, 0, 0); // release 2
        vecs[17] = mk(0, 1, 0, 0, 8'h00, 0, 0,  64, 1, 32'h10101010, 0, 1, 0);
        vecs[18] = mk(0, 1, 0, 0, 8'h00, 0, 1,  10, 0, 32'h00000000, 3, 0, 0); // saturate
        vecs[19] = mk(0, 1, 0, 0, 8'h00, 0, 1,   8, 1, 32'h02020202, 3, 1, 0);
        vecs[20] = mk(0, 1, 1, 0, 8'hFF, 0, 1,   1, 1, 32'h02020202, 3, 1, 0); // write FF
        vecs[21] = mk(0, 1, 0, 0, 8'h00, 0, 1, 120, 1, 32'h0202021F, 3, 1, 0);
        vecs[22] = mk(0, 0, 1, 1, 8'h08, 0, 1,   1, 1, 32'h0202021F, 3, 1, 0); // cen=0 write
        vecs[23] = mk(0, 0, 0, 0, 8'h00, 0, 1,  20, 1, 32'h0202021F, 3, 1, 1); // frozen
        vecs[24] = mk(0, 0, 0, 0, 8'h00, 0, 0,  20, 1, 32'h0202021F, 3, 1, 1);
        vecs[25] = mk(1, 1, 0, 0, 8'h00, 0, 0,   1, 1, 32'h00000000, 0, 1, 0); // reset
        vecs[26] = mk(0, 1, 0, 0, 8'h00, 0, 0,   3, 1, 32'h00000000, 0, 1, 1);
        vecs[27] = mk(0, 1, 1, 0, 8'h00, 0, 0,   1, 1, 32'h01010101, 0, 1, 1); // wr on up_tick
        vecs[28] = mk(0, 1, 0, 0, 8'h00, 0, 0,   1, 1, 32'h01010100, 0, 1, 1);
        vecs[29] = mk(1, 1, 0, 0, 8'h00, 0, 0,   1, 1, 32'h00000000, 0, 1, 0); // reset mid-ramp
        vecs[30] = mk(0, 1, 0, 0, 8'h00, 0, 0,  64, 1, 32'h10101010, 0, 1, 1); // targets restored
        vecs[31] = mk(0, 1, 0, 0, 8'h00, 0, 0,   1, 1, 32'h10101010, 0, 1, 0);

        for (int v = 0; v < NVEC; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                apply(vecs[v].rst, vecs[v].cen, vecs[v].wr, vecs[v].waddr,
                      vecs[v].wdata, vecs[v].mute, vecs[v].peak);
            end
            act_g = {gain3, gain2, gain1, gain0};
            $display("vec %0d: n=%0d gains=%h att=%0d ramping=%0d", v, vecs[v].n, act_g, att, ramping);
            if (vecs[v].chk_g) begin
                n_checks++;
                if (act_g !== vecs[v].e_g) begin
                    n_fail++;
                    $display("FAIL vec%0d gains got=%h want=%h", v, act_g, vecs[v].e_g);
                end
            end
            n_checks++;
            if (att !== vecs[v].e_att) begin
                n_fail++;
                $display("FAIL vec%0d att got=%0d want=%0d", v, att, vecs[v].e_att);
            end
            if (vecs[v].chk_r) begin
                n_checks++;
                if (ramping !== vecs[v].e_r) begin
                    n_fail++;
                    $display("FAIL vec%0d ramping got=%0d want=%0d", v, ramping, vecs[v].e_r);
                end
            end
        end

        // Randomized traffic, every clk compared against the model.
        rmute = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            logic r, c, w, p;
            logic [1:0] a;
            logic [7:0] d;
            r = ($urandom_range(0, 499) == 0);
            c = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 9) == 0);
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            p = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) rmute = ~rmute;
            apply(r, c, w, a, d, rmute, p);
            if (w || r)
                $display("rand cyc=%0d rst=%0d wr=%0d ch=%0d data=%h gains=%h att=%0d",
                         cyc, r, w, a, d, {gain3, gain2, gain1, gain0}, att);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mixer_gain_ctrl.md
Name: mixer_gain_ctrl

Overview:
Run-time gain controller for the 4-channel unsigned mixer. It generates the four 4.4 fixed-point gain inputs (gain0..gain3) from CPU-written target gains. Gains ramp smoothly to avoid zipper noise. A mute input and a peak-driven limiter attenuate all channels. It sits between the sound CPU register decode and the mixer, and is clocked on the same clk/cen.

Parameters:
UP_DIV, 256, cen ticks between upward gain steps (must be at least 1)
DN_DIV, 16, cen ticks between downward gain steps (must be at least 1)
PEAK_HOLD, 1024, cen ticks without peak before limiter releases one level
MAX_ATT, 3, maximum limiter attenuation level (each level = right shift by 1)
RST_TGT, 8'h10, target gain after reset (1.0 in 4.4)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cen  in  1  mixer clock enable; all timing counters advance only when cen=1
wr  in  1  register write strobe, one clk, not gated by cen
waddr  in  2  channel index for write
wdata  in  8  new target gain, 4.4 format
mute  in  1  level: when 1, effective targets are forced to 0
peak  in  1  mixer overflow flag, sampled only when cen=1
gain0..gain3  out  8 each  current gain per channel to mixer
att  out  2  current limiter attenuation level, 0..MAX_ATT
ramping  out  1  1 while any gain differs from its effective target

Behaviour:
- Reset values: gain0..3=0, target[0..3]=RST_TGT, att=0, both dividers=0, hold counter=PEAK_HOLD-1, ramping=0 registered (becomes 1 the cycle after reset releases). After reset, gains soft-start from 0 toward RST_TGT.
- Write: when wr=1, target[waddr]<=wdata on that clk regardless of cen or ramp state. The new target is used for comparison from the next clk. Back-to-back writes are all accepted. A write to the same channel on consecutive clks keeps the last one.
- Effective target: eff[i] = mute ? 0 : (target[i] >> att). Purely combinational from registered values.
- Dividers: up_cnt and dn_cnt are free-running mod-UP_DIV and mod-DN_DIV counters advancing on cen. up_tick is asserted when up_cnt==UP_DIV-1 and cen=1; dn_tick likewise.
- Ramp, per channel, evaluated every clk:
  - if gain<eff and up_tick, then gain+1;
  - else if gain>eff and dn_tick, then gain-1;
  - otherwise hold.
  - Step size is always 1 LSB (1/16). A gain never overshoots its effective target, and there is no wrap at 0 or 8'hFF.
- Limiter (evaluated only when cen=1):
  - peak=1: att<=min(att+1,MAX_ATT), hold<=PEAK_HOLD-1.
  - peak=0 and hold==0: att<=max(att-1,0), hold<=PEAK_HOLD-1.
  - peak=0 and hold>0: hold<=hold-1.
  - Consecutive peaks raise att by one level per cen until it saturates.
- ramping is registered: 1 when any gain[i]!=eff[i] at the previous clk.
- Simultaneous events:
  - write + tick on same clk: the tick uses the old target.
  - up_tick and dn_tick on the same clk: each channel moves in only its own direction.
  - mute toggling mid-ramp: the ramp retargets immediately with no jump.
  - att change mid-ramp: the ramp retargets, with no jump.
- Reset mid-ramp: all state returns to reset values on the next clk edge, and gains drop instantly to 0.
- Latency: from a write to the first gain movement is at most UP_DIV or DN_DIV cen ticks plus 1 clk.

Decomposition:
- Shared package mixer_pkg:
  - 4.4 gain width constant (GW=8)
  - unity gain constant 8'h10
  - channel count NCH=4
  - attenuation width
- One natural sub-module, gain_ramp: a single-channel target/current register with up/down step logic, instantiated 4 times.
- Dividers, limiter and write decode live in the top level.

Test Plan:
- Soft start (UP_DIV=4, DN_DIV=1, cen=1 always, PEAK_HOLD=8): release reset -> gain0..3 rise 0,1,2,.. one step per 4 clk; reach 8'h10 after 64 clk; ramping falls 1 clk after.
- Write: at steady 8'h10, wr waddr=2 wdata=8'h04 -> gain2 drops by 1 per clk to 8'h04 in 12 clk; other gains unchanged at 8'h10.
- Mute: steady 8'h10, mute=1 -> all gains reach 0 in 16 clk; mute=0 -> all return to 8'h10 in 64 clk.
- Limiter: steady 8'h10, peak=1 for 2 cen -> att=2, gains settle at 8'h04; peak=0 -> att=1 after 8 cen, att=0 after 16 cen; gains ramp back to 8'h10.
- Saturation: peak held 1 for 10 cen -> att stops at 3, gains settle at 8'h02; write wdata=8'hFF to ch0 -> gain0 targets 8'h1F without wrap.
- Corner cases: wr coincident with up_tick -> that tick uses the old target. rst asserted mid-ramp -> gains=0 and targets=8'h10 next clk. cen held 0 -> gains frozen while writes still update target.
